// File: rtl/phy_rx_pkg.sv
// Shared constants and types for the PHY RX lane arbiter slice.
package phy_rx_pkg;

  localparam int LANES     = 4;
  localparam int BYTE_W    = 8;
  localparam int LANE_ID_W = 2;

  typedef logic [LANE_ID_W-1:0] lane_id_t;

  // Last-granted lane after reset/flush, so lane 0 is scanned first.
  localparam lane_id_t RR_RESET_LAST = 2'd3;

endpackage

// File: rtl/phy_rx_lane_fifo.sv
// Small per-lane elastic buffer; head byte is visible combinationally on dout.
module phy_rx_lane_fifo
  import phy_rx_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [BYTE_W-1:0] mem [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_4f) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/phy_rx_lane_arbiter.sv
// Round-robin arbiter sharing one downstream byte port between four RX lanes,
// with per-lane elastic buffers, pause/flush handling and drop accounting.
module phy_rx_lane_arbiter
  import phy_rx_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DROP_W = 8
) (
  input  logic                 clk_4f,
  input  logic                 reset,
  input  logic [BYTE_W-1:0]    data_0,
  input  logic [BYTE_W-1:0]    data_1,
  input  logic [BYTE_W-1:0]    data_2,
  input  logic [BYTE_W-1:0]    data_3,
  input  logic                 valid_0,
  input  logic                 valid_1,
  input  logic                 valid_2,
  input  logic                 valid_3,
  input  logic                 pause,
  input  logic                 flush,
  output logic [BYTE_W-1:0]    data_out,
  output logic                 valid_out,
  output logic [LANE_ID_W-1:0] lane_id,
  output logic [LANES-1:0]     overflow,
  output logic [DROP_W-1:0]    drop_cnt,
  output logic                 idle
);

  logic [BYTE_W-1:0] lane_data [LANES];
  logic [BYTE_W-1:0] lane_head [LANES];
  logic [LANES-1:0]  lane_valid;
  logic [LANES-1:0]  lane_full;
  logic [LANES-1:0]  lane_empty;
  logic [LANES-1:0]  lane_push;
  logic [LANES-1:0]  lane_pop;
  logic [LANES-1:0]  lane_drop;

  lane_id_t          last;
  lane_id_t          winner;
  lane_id_t          scan_idx;
  logic              any_ready;
  logic              grant;
  logic [2:0]        drop_sum;
  logic [DROP_W:0]   drop_next;

  assign lane_data[0] = data_0;
  assign lane_data[1] = data_1;
  assign lane_data[2] = data_2;
  assign lane_data[3] = data_3;
  assign lane_valid   = {valid_3, valid_2, valid_1, valid_0};

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    phy_rx_lane_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk_4f(clk_4f),
      .reset (reset),
      .flush (flush),
      .push  (lane_push[g]),
      .pop   (lane_pop[g]),
      .din   (lane_data[g]),
      .dout  (lane_head[g]),
      .full  (lane_full[g]),
      .empty (lane_empty[g])
    );
  end

  // Scan last+1 .. last+4 (mod 4); the first non-empty lane wins.
  always_comb begin
    winner    = last;
    scan_idx  = last;
    any_ready = 1'b0;
    for (int i = 1; i <= LANES; i++) begin
      scan_idx = last + lane_id_t'(i);
      if (!any_ready && !lane_empty[scan_idx]) begin
        winner    = scan_idx;
        any_ready = 1'b1;
      end
    end
    grant = any_ready && !pause && !flush;
  end

  // A full lane may still accept a byte when its head leaves on the same edge.
  always_comb begin
    lane_pop  = '0;
    lane_push = '0;
    lane_drop = '0;
    drop_sum  = '0;
    for (int n = 0; n < LANES; n++) begin
      lane_pop[n]  = grant && (winner == lane_id_t'(n));
      lane_push[n] = lane_valid[n] && !flush && (!lane_full[n] || lane_pop[n]);
      lane_drop[n] = lane_valid[n] && !flush && !lane_push[n];
      drop_sum     = drop_sum + 3'(lane_drop[n]);
    end
  end

  assign drop_next = {1'b0, drop_cnt} + (DROP_W+1)'(drop_sum);

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      overflow <= '0;
      drop_cnt <= '0;
    end else begin
      overflow <= overflow | lane_drop;
      drop_cnt <= drop_next[DROP_W] ? '1 : drop_next[DROP_W-1:0];
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      lane_id   <= '0;
      last      <= RR_RESET_LAST;
    end else if (grant) begin
      data_out  <= lane_head[winner];
      lane_id   <= winner;
      valid_out <= 1'b1;
      last      <= winner;
    end else begin
      valid_out <= 1'b0;
      if (flush) last <= RR_RESET_LAST;
    end
  end

  assign idle = (&lane_empty) && !valid_out;

endmodule

// File: tb/tb_phy_rx_lane_arbiter.sv
// Scoreboard bench for phy_rx_lane_arbiter: directed stimulus pushes expected
// grants, a negedge monitor pops and compares whenever valid_out is high.
module tb_phy_rx_lane_arbiter;

  logic       clk_4f = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] data_0 = '0, data_1 = '0, data_2 = '0, data_3 = '0;
  logic       valid_0 = 1'b0, valid_1 = 1'b0, valid_2 = 1'b0, valid_3 = 1'b0;
  logic       pause = 1'b0, flush = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_id;
  logic [3:0] overflow;
  logic [7:0] drop_cnt;
  logic       idle;

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [9:0] sb_q [$];
  logic [9:0] mon_exp;

  phy_rx_lane_arbiter #(.DEPTH(2), .DROP_W(8)) dut (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .data_0   (data_0),
    .data_1   (data_1),
    .data_2   (data_2),
    .data_3   (data_3),
    .valid_0  (valid_0),
    .valid_1  (valid_1),
    .valid_2  (valid_2),
    .valid_3  (valid_3),
    .pause    (pause),
    .flush    (flush),
    .data_out (data_out),
    .valid_out(valid_out),
    .lane_id  (lane_id),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .idle     (idle)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let the next edge sample them, return 1 ns after it.
  task automatic applyStimulus(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3,
                               input logic p, input logic f);
    valid_0 = v[0]; valid_1 = v[1]; valid_2 = v[2]; valid_3 = v[3];
    data_0 = d0; data_1 = d1; data_2 = d2; data_3 = d3;
    pause = p; flush = f;
    @(posedge clk_4f); #1;
  endtask

  task automatic clearStrobes();
    valid_0 = 1'b0; valid_1 = 1'b0; valid_2 = 1'b0; valid_3 = 1'b0;
    flush = 1'b0;
  endtask

  task automatic pushExpected(input logic [7:0] d, input logic [1:0] lane);
    sb_q.push_back({d, lane});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk_4f);
    checkOutput({name, "_drained"}, 32'(sb_q.size()), 32'd0);
    @(posedge clk_4f); #1;
  endtask

  always @(negedge clk_4f) begin
    if (!reset && valid_out) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL unexpected_grant: got data 0x%0h lane %0d, expected no output", data_out, lane_id);
      end else begin
        mon_exp = sb_q.pop_front();
        checkOutput("grant", 32'({data_out, lane_id}), 32'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Test 1: reset values, then one byte on every lane.
    repeat (2) @(posedge clk_4f);
    #1;
    reset = 1'b0;
    checkOutput("rst_data_out", 32'(data_out), 32'h0);
    checkOutput("rst_valid_out", 32'(valid_out), 32'h0);
    checkOutput("rst_lane_id", 32'(lane_id), 32'h0);
    checkOutput("rst_overflow", 32'(overflow), 32'h0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    checkOutput("rst_idle", 32'(idle), 32'h1);

    pushExpected(8'h11, 2'd0);
    pushExpected(8'h22, 2'd1);
    pushExpected(8'h33, 2'd2);
    pushExpected(8'h44, 2'd3);
    applyStimulus(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0);
    clearStrobes();
    drain("t1");
    checkOutput("t1_valid_out", 32'(valid_out), 32'h0);
    checkOutput("t1_idle", 32'(idle), 32'h1);

    // Test 2: continuous stream on lane 2.
    for (int i = 0; i < 8; i++) begin
      pushExpected(8'(8'hA0 + i), 2'd2);
      applyStimulus(4'b0100, 8'h00, 8'h00, 8'(8'hA0 + i), 8'h00, 1'b0, 1'b0);
      if (i > 0) checkOutput("t2_stream_valid", 32'({valid_out, lane_id}), 32'h6);
    end
    clearStrobes();
    drain("t2");
    checkOutput("t2_drop_cnt", 32'(drop_cnt), 32'h0);

    // Test 3: overflow of lane 1 while paused.
    applyStimulus(4'b0010, 8'h00, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
    applyStimulus(4'b0010, 8'h00, 8'h02, 8'h00, 8'h00, 1'b1, 1'b0);
    applyStimulus(4'b0010, 8'h00, 8'h03, 8'h00, 8'h00, 1'b1, 1'b0);
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("t3_overflow", 32'(overflow), 32'h2);
    checkOutput("t3_drop_cnt", 32'(drop_cnt), 32'h1);
    checkOutput("t3_paused_valid", 32'(valid_out), 32'h0);
    pushExpected(8'h01, 2'd1);
    pushExpected(8'h02, 2'd1);
    pause = 1'b0;
    drain("t3");

    // Test 4: lanes 0 and 3 alternating.
    for (int i = 0; i < 4; i++) begin
      pushExpected(8'(8'hB0 + i), 2'd0);
      applyStimulus(4'b0001, 8'(8'hB0 + i), 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      pushExpected(8'(8'hC0 + i), 2'd3);
      applyStimulus(4'b1000, 8'h00, 8'h00, 8'h00, 8'(8'hC0 + i), 1'b0, 1'b0);
    end
    clearStrobes();
    drain("t4");
    checkOutput("t4_drop_cnt", 32'(drop_cnt), 32'h1);
    checkOutput("t4_overflow", 32'(overflow), 32'h2);

    // Test 5: asynchronous reset with data buffered in three lanes.
    applyStimulus(4'b0111, 8'hD0, 8'hD1, 8'hD2, 8'h00, 1'b1, 1'b0);
    clearStrobes();
    pushExpected(8'hD0, 2'd0);
    pause = 1'b0;
    @(posedge clk_4f);
    #6;
    reset = 1'b1;
    #1;
    checkOutput("t5_async_valid_out", 32'(valid_out), 32'h0);
    checkOutput("t5_async_data_out", 32'(data_out), 32'h0);
    checkOutput("t5_async_drop_cnt", 32'(drop_cnt), 32'h0);
    checkOutput("t5_async_overflow", 32'(overflow), 32'h0);
    checkOutput("t5_async_idle", 32'(idle), 32'h1);
    checkOutput("t5_sb_consumed", 32'(sb_q.size()), 32'h0);
    @(posedge clk_4f); #1;
    reset = 1'b0;
    pushExpected(8'hE0, 2'd0);
    pushExpected(8'hE1, 2'd1);
    applyStimulus(4'b0011, 8'hE0, 8'hE1, 8'h00, 8'h00, 1'b0, 1'b0);
    clearStrobes();
    drain("t5");

    // Test 6: flush with lane 1 full and strobes on lanes 0 and 1.
    applyStimulus(4'b0010, 8'h00, 8'h61, 8'h00, 8'h00, 1'b1, 1'b0);
    applyStimulus(4'b0010, 8'h00, 8'h62, 8'h00, 8'h00, 1'b1, 1'b0);
    applyStimulus(4'b0011, 8'h70, 8'h71, 8'h00, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("t6_idle", 32'(idle), 32'h1);
    checkOutput("t6_drop_cnt", 32'(drop_cnt), 32'h0);
    checkOutput("t6_overflow", 32'(overflow), 32'h0);
    pushExpected(8'h90, 2'd0);
    pushExpected(8'h92, 2'd2);
    applyStimulus(4'b0101, 8'h90, 8'h00, 8'h92, 8'h00, 1'b0, 1'b0);
    clearStrobes();
    drain("t6");

    // Test 7: simultaneous multi-lane drops and counter saturation.
    applyStimulus(4'b1111, 8'h50, 8'h51, 8'h52, 8'h53, 1'b1, 1'b0);
    applyStimulus(4'b1111, 8'h50, 8'h51, 8'h52, 8'h53, 1'b1, 1'b0);
    checkOutput("t7_no_drop_yet", 32'(drop_cnt), 32'h0);
    applyStimulus(4'b1111, 8'h50, 8'h51, 8'h52, 8'h53, 1'b1, 1'b0);
    checkOutput("t7_four_drops", 32'(drop_cnt), 32'h4);
    for (int i = 0; i < 70; i++) applyStimulus(4'b1111, 8'h50, 8'h51, 8'h52, 8'h53, 1'b1, 1'b0);
    checkOutput("t7_saturated", 32'(drop_cnt), 32'hFF);
    checkOutput("t7_overflow", 32'(overflow), 32'hF);
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("t7_idle", 32'(idle), 32'h1);
    checkOutput("t7_sat_hold", 32'(drop_cnt), 32'hFF);
    checkOutput("t7_sb_empty", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
